mvc_txn_monitor: RTL and testbench

Passive stream monitor that snoops a valid/ready beat interface, groups beats into transactions delimited by `mon_last`, and emits one descriptor per transaction through a small FIFO. Each descriptor holds the start timestamp, beat count, XOR checksum and an error flag. It sits between the DUT-facing stream interface and the `mvc_pkg` checker/scoreboard, supplying it with compact transaction records. It never drives the monitored bus.

---
 rtl/mvc_pkg.sv | 27 ++
 rtl/mvc_sync_fifo.sv | 66 ++++++
 rtl/mvc_txn_monitor.sv | 139 +++++++++++++
 tb/tb_mvc_txn_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mvc_pkg.sv
// Shared types and constants for the mvc transaction monitor and its checker.
package mvc_pkg;

    localparam int MVC_DATA_W     = 32;
    localparam int MVC_TS_W       = 32;
    localparam int MVC_MAX_BEATS  = 256;
    localparam int MVC_BEATS_W    = $clog2(MVC_MAX_BEATS + 1);
    localparam int MVC_FIFO_DEPTH = 8;
    localparam int MVC_DROP_CNT_W = 16;

    typedef struct packed {
        logic [MVC_TS_W-1:0]    start_ts;
        logic [MVC_BEATS_W-1:0] beats;
        logic [MVC_DATA_W-1:0]  csum;
        logic                   err;
    } mvc_txn_desc_t;

    typedef enum logic [0:0] {
        MVC_IDLE   = 1'b0,
        MVC_ACTIVE = 1'b1
    } mvc_mon_state_e;

    function automatic logic [MVC_DROP_CNT_W-1:0] mvc_sat_inc(input logic [MVC_DROP_CNT_W-1:0] v);
        return (v == {MVC_DROP_CNT_W{1'b1}}) ? v : v + MVC_DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/mvc_sync_fifo.sv
// Generic synchronous FIFO with a registered head-of-queue output; a push is
// accepted while full when a pop happens in the same cycle.
module mvc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    remain;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_nxt = rd_ptr + AW'(do_pop);
        remain     = count - CW'(do_pop);
        count_nxt  = remain + CW'(do_push);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // The head register is refilled from storage, or straight from din when
    // the queue would otherwise be empty, so dout is valid the cycle after a push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            empty  <= (count_nxt == CW'(0));
            if (count_nxt != CW'(0)) begin
                dout <= (remain == CW'(0)) ? din : mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/mvc_txn_monitor.sv
// Passive valid/ready stream monitor: folds beats into per-transaction
// descriptors (start time, beat count, XOR checksum, error) and queues them.
module mvc_txn_monitor
    import mvc_pkg::*;
#(
    parameter int DATA_W    = MVC_DATA_W,
    parameter int DEPTH     = MVC_FIFO_DEPTH,
    parameter int MAX_BEATS = MVC_MAX_BEATS,
    parameter int TS_W      = MVC_TS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mon_valid,
    input  logic                      mon_ready,
    input  logic [DATA_W-1:0]         mon_data,
    input  logic                      mon_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output mvc_txn_desc_t             out_desc,
    output logic [MVC_DROP_CNT_W-1:0] drop_cnt,
    output logic                      ovf_flag
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    mvc_mon_state_e state;
    mvc_mon_state_e state_nxt;

    logic [TS_W-1:0]   ts;
    logic [TS_W-1:0]   acc_ts;
    logic [TS_W-1:0]   acc_ts_nxt;
    logic [BW-1:0]     acc_beats;
    logic [BW-1:0]     acc_beats_nxt;
    logic [DATA_W-1:0] acc_csum;
    logic [DATA_W-1:0] acc_csum_nxt;
    logic              acc_err;
    logic              acc_err_nxt;

    logic              beat;
    logic              at_max;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    mvc_txn_desc_t     push_desc;

    assign beat   = mon_valid && mon_ready;
    assign at_max = (acc_beats == BW'(MAX_BEATS));

    // The descriptor pushed on a last beat is exactly the updated accumulator,
    // so single-beat and multi-beat transactions share one build path.
    always_comb begin
        state_nxt     = state;
        acc_ts_nxt    = acc_ts;
        acc_beats_nxt = acc_beats;
        acc_csum_nxt  = acc_csum;
        acc_err_nxt   = acc_err;
        push          = 1'b0;
        case (state)
            MVC_IDLE: begin
                if (beat) begin
                    acc_ts_nxt    = ts;
                    acc_beats_nxt = BW'(1);
                    acc_csum_nxt  = mon_data;
                    acc_err_nxt   = 1'b0;
                    if (mon_last) begin
                        push = 1'b1;
                    end else begin
                        state_nxt = MVC_ACTIVE;
                    end
                end
            end
            MVC_ACTIVE: begin
                if (beat) begin
                    acc_beats_nxt = at_max ? acc_beats : acc_beats + BW'(1);
                    acc_err_nxt   = acc_err || at_max;
                    acc_csum_nxt  = acc_csum ^ mon_data;
                    if (mon_last) begin
                        push      = 1'b1;
                        state_nxt = MVC_IDLE;
                    end
                end
            end
            default: state_nxt = MVC_IDLE;
        endcase
    end

    always_comb begin
        push_desc          = '0;
        push_desc.start_ts = MVC_TS_W'(acc_ts_nxt);
        push_desc.beats    = MVC_BEATS_W'(acc_beats_nxt);
        push_desc.csum     = MVC_DATA_W'(acc_csum_nxt);
        push_desc.err      = acc_err_nxt;
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts        <= '0;
            state     <= MVC_IDLE;
            acc_ts    <= '0;
            acc_beats <= '0;
            acc_csum  <= '0;
            acc_err   <= 1'b0;
            drop_cnt  <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            ts        <= ts + TS_W'(1);
            state     <= state_nxt;
            acc_ts    <= acc_ts_nxt;
            acc_beats <= acc_beats_nxt;
            acc_csum  <= acc_csum_nxt;
            acc_err   <= acc_err_nxt;
            if (drop) begin
                drop_cnt <= mvc_sat_inc(drop_cnt);
                ovf_flag <= 1'b1;
            end
        end
    end

    mvc_sync_fifo #(
        .WIDTH ($bits(mvc_txn_desc_t)),
        .DEPTH (DEPTH)
    ) u_desc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_desc),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (out_desc),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_mvc_txn_monitor.sv
// Self-checking bench for mvc_txn_monitor: directed scenarios plus random
// traffic, scored against a transaction-level model kept in the bench.
module tb_mvc_txn_monitor;
    import mvc_pkg::*;

    localparam int DEPTH = MVC_FIFO_DEPTH;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      mon_valid;
    logic                      mon_ready;
    logic [MVC_DATA_W-1:0]     mon_data;
    logic                      mon_last;
    logic                      out_valid;
    logic                      out_ready;
    mvc_txn_desc_t             out_desc;
    logic [MVC_DROP_CNT_W-1:0] drop_cnt;
    logic                      ovf_flag;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    mvc_txn_desc_t m_q[$];
    logic [31:0]   m_ts;
    logic [31:0]   m_start;
    logic [31:0]   m_csum;
    int            m_n;
    logic          m_active;
    int            m_drops;
    logic          m_ovf;

    mvc_txn_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .mon_valid (mon_valid),
        .mon_ready (mon_ready),
        .mon_data  (mon_data),
        .mon_last  (mon_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_desc  (out_desc),
        .drop_cnt  (drop_cnt),
        .ovf_flag  (ovf_flag)
    );

    always #5 clk = ~clk;

    function automatic mvc_txn_desc_t mkDesc(input logic [31:0] ts, input int n,
                                             input logic [31:0] csum, input logic err);
        mvc_txn_desc_t d;
        d.start_ts = ts;
        d.beats    = MVC_BEATS_W'((n > MVC_MAX_BEATS) ? MVC_MAX_BEATS : n);
        d.csum     = csum;
        d.err      = err;
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic last,
                                 input logic [31:0] data, input logic ordy);
        mon_valid = v;
        mon_ready = r;
        mon_last  = last;
        mon_data  = data;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Transaction-level reference: a transaction is the list of beats up to
    // the last marker; the queue accepts it if there is room after this cycle's pop.
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_ts     = 0;
            m_active = 1'b0;
            m_n      = 0;
            m_csum   = 0;
            m_start  = 0;
            m_drops  = 0;
            m_ovf    = 1'b0;
        end else begin
            logic do_pop;
            logic do_push;
            mvc_txn_desc_t d;
            do_pop  = (m_q.size() > 0) && out_ready;
            do_push = 1'b0;
            d       = '0;
            if (mon_valid && mon_ready) begin
                if (!m_active) begin
                    m_start  = m_ts;
                    m_n      = 0;
                    m_csum   = 0;
                    m_active = 1'b1;
                end
                m_n++;
                m_csum ^= mon_data;
                if (mon_last) begin
                    d        = mkDesc(m_start, m_n, m_csum, m_n > MVC_MAX_BEATS);
                    do_push  = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else begin
                    if (m_drops < 65535) m_drops++;
                    m_ovf = 1'b1;
                end
            end
            m_ts++;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            checkOutput("sb_out_valid", out_valid, m_q.size() > 0);
            if (m_q.size() > 0) checkOutput("sb_out_desc", out_desc, m_q[0]);
            checkOutput("sb_drop_cnt", drop_cnt, m_drops);
            checkOutput("sb_ovf_flag", ovf_flag, m_ovf);
        end
    end

    initial begin
        logic [31:0] first_ts;
        logic [31:0] csum;
        logic [31:0] d;
        rst = 1'b1;
        mon_valid = 0; mon_ready = 0; mon_last = 0; mon_data = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_desc", out_desc, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        checkOutput("rst_ovf_flag", ovf_flag, 0);
        rst = 1'b0;

        $display("[TB] single beat at ts=10");
        while (m_ts != 10) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'hA5A5A5A5, 0);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_desc", out_desc, mkDesc(10, 1, 32'hA5A5A5A5, 0));
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_stable", out_desc, mkDesc(10, 1, 32'hA5A5A5A5, 0));
        drain(2);

        $display("[TB] four beats with stalls");
        first_ts = m_ts;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, i == 3, 32'h1 << i, 0);
            if (i < 3) begin
                applyStimulus(1, 0, 0, 32'hDEAD0000, 0);
                applyStimulus(0, 1, 1, 32'hBEEF0000, 0);
            end
        end
        checkOutput("t2_desc", out_desc, mkDesc(first_ts, 4, 32'hF, 0));
        drain(2);

        $display("[TB] over-length transaction");
        first_ts = m_ts;
        csum = 0;
        for (int i = 1; i <= MVC_MAX_BEATS + 3; i++) begin
            d = $urandom;
            csum ^= d;
            applyStimulus(1, 1, i == MVC_MAX_BEATS + 3, d, 0);
        end
        checkOutput("t3_long", out_desc, mkDesc(first_ts, 256, csum, 1));
        drain(2);
        first_ts = m_ts;
        applyStimulus(1, 1, 0, 32'h3, 0);
        applyStimulus(1, 1, 1, 32'h5, 0);
        checkOutput("t3_clean", out_desc, mkDesc(first_ts, 2, 32'h6, 0));
        drain(2);

        $display("[TB] overflow with consumer stalled");
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, i, 0);
        checkOutput("t4_drop_cnt", drop_cnt, 2);
        checkOutput("t4_ovf", ovf_flag, 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t4_drain_valid", out_valid, 1);
            checkOutput("t4_drain_csum", out_desc.csum, i);
            applyStimulus(0, 0, 0, 0, 1);
        end
        checkOutput("t4_empty", out_valid, 0);

        $display("[TB] push and pop while full");
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, 100 + i, 0);
        applyStimulus(1, 1, 1, 200, 1);
        checkOutput("t5_drop_cnt", drop_cnt, 2);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("t5_order", out_desc.csum, (i == 8) ? 200 : 100 + i);
            applyStimulus(0, 0, 0, 0, 1);
        end
        checkOutput("t5_empty", out_valid, 0);

        $display("[TB] reset mid-transaction");
        applyStimulus(1, 1, 0, 32'h11, 0);
        applyStimulus(1, 1, 0, 32'h22, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_rst_valid", out_valid, 0);
        checkOutput("t6_rst_drop", drop_cnt, 0);
        checkOutput("t6_rst_ovf", ovf_flag, 0);
        rst = 1'b0;
        applyStimulus(1, 1, 1, 32'h77, 0);
        checkOutput("t6_desc", out_desc, mkDesc(0, 1, 32'h77, 0));
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t6_only_one", out_valid, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 2) != 0);
        end
        drain(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
